// File: rtl/twave_cfg_ctrl.sv
// Triangle-carrier configuration controller: validates carrier settings, defers
// run-time updates to the next carrier valley, and counts carrier periods.
module twave_cfg_ctrl #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned CNT_W     = 16,
  parameter logic [BIT_WIDTH-1:0] DEF_UPPER = 16'hFFFF,
  parameter logic [BIT_WIDTH-1:0] DEF_LOWER = 16'h0000,
  parameter logic [BIT_WIDTH-1:0] DEF_STEP  = 16'h0001
) (
  input  logic                 MClk,
  input  logic                 RstN,
  input  logic                 Start,
  input  logic                 Stop,
  input  logic                 CfgValid,
  output logic                 CfgReady,
  input  logic [BIT_WIDTH-1:0] CfgUpper,
  input  logic [BIT_WIDTH-1:0] CfgLower,
  input  logic [BIT_WIDTH-1:0] CfgStep,
  input  logic [BIT_WIDTH-1:0] TWave,
  output logic                 GenEn,
  output logic [BIT_WIDTH-1:0] UpperLimit,
  output logic [BIT_WIDTH-1:0] LowerLimit,
  output logic [BIT_WIDTH-1:0] StepSize,
  output logic                 CfgErr,
  output logic                 ValleyPulse,
  output logic [CNT_W-1:0]     PeriodCnt
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] shUpper, shLower, shStep;
  logic [BIT_WIDTH-1:0] prevWave;
  logic [BIT_WIDTH-1:0] cfgSpan;
  logic                 falling, trkArmed;
  logic                 accept, cfgOk, valleyDet;

  assign accept    = CfgValid & CfgReady;
  assign cfgSpan   = CfgUpper - CfgLower;
  assign cfgOk     = (CfgLower < CfgUpper) && (CfgStep != '0) && (CfgStep <= cfgSpan);
  assign valleyDet = GenEn & trkArmed & falling & (TWave > prevWave);

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      state       <= IDLE;
      CfgReady    <= 1'b1;
      GenEn       <= 1'b0;
      UpperLimit  <= DEF_UPPER;
      LowerLimit  <= DEF_LOWER;
      StepSize    <= DEF_STEP;
      CfgErr      <= 1'b0;
      ValleyPulse <= 1'b0;
      PeriodCnt   <= '0;
      shUpper     <= '0;
      shLower     <= '0;
      shStep      <= '0;
      prevWave    <= '0;
      falling     <= 1'b0;
      trkArmed    <= 1'b0;
    end else begin
      ValleyPulse <= valleyDet;
      if (valleyDet) PeriodCnt <= PeriodCnt + 1'b1;

      // The first enabled cycle carries no valid sample, so the tracker only arms then.
      if (!GenEn || !trkArmed) begin
        prevWave <= '0;
        falling  <= 1'b0;
        trkArmed <= GenEn;
      end else begin
        prevWave <= TWave;
        if (valleyDet)             falling <= 1'b0;
        else if (TWave < prevWave) falling <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            if (cfgOk) begin
              UpperLimit <= CfgUpper;
              LowerLimit <= CfgLower;
              StepSize   <= CfgStep;
              CfgErr     <= 1'b0;
            end else begin
              CfgErr <= 1'b1;
            end
          end
          if (Start && !Stop) begin
            state     <= RUN;
            GenEn     <= 1'b1;
            PeriodCnt <= '0;
          end
        end
        RUN: begin
          if (Stop) begin
            state <= IDLE;
            GenEn <= 1'b0;
          end else if (accept) begin
            if (cfgOk) begin
              shUpper  <= CfgUpper;
              shLower  <= CfgLower;
              shStep   <= CfgStep;
              CfgErr   <= 1'b0;
              CfgReady <= 1'b0;
              state    <= PEND;
            end else begin
              CfgErr <= 1'b1;
            end
          end
        end
        PEND: begin
          if (Stop || ValleyPulse) begin
            UpperLimit <= shUpper;
            LowerLimit <= shLower;
            StepSize   <= shStep;
            CfgReady   <= 1'b1;
            if (Stop) begin
              GenEn <= 1'b0;
              state <= IDLE;
            end else begin
              state <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twave_cfg_ctrl.sv
// Directed bench for twave_cfg_ctrl with a simple triangle generator driving TWave.
module tb_twave_cfg_ctrl;

  logic        MClk = 1'b0;
  logic        RstN, Start, Stop, CfgValid;
  logic        CfgReady, GenEn, CfgErr, ValleyPulse;
  logic [15:0] CfgUpper, CfgLower, CfgStep, TWave;
  logic [15:0] UpperLimit, LowerLimit, StepSize, PeriodCnt;
  logic        waveUp;
  int          total = 0;
  int          bad   = 0;

  always #5 MClk = ~MClk;

  twave_cfg_ctrl #(
    .BIT_WIDTH(16),
    .CNT_W(16),
    .DEF_UPPER(16'hFFFF),
    .DEF_LOWER(16'h0000),
    .DEF_STEP(16'h0001)
  ) dut (
    .MClk(MClk), .RstN(RstN), .Start(Start), .Stop(Stop),
    .CfgValid(CfgValid), .CfgReady(CfgReady),
    .CfgUpper(CfgUpper), .CfgLower(CfgLower), .CfgStep(CfgStep),
    .TWave(TWave), .GenEn(GenEn),
    .UpperLimit(UpperLimit), .LowerLimit(LowerLimit), .StepSize(StepSize),
    .CfgErr(CfgErr), .ValleyPulse(ValleyPulse), .PeriodCnt(PeriodCnt)
  );

  // Triangle generator: ramps from LowerLimit to UpperLimit and back while enabled.
  always @(posedge MClk) begin
    if (!GenEn) begin
      TWave  <= LowerLimit;
      waveUp <= 1'b1;
    end else if (waveUp) begin
      if ({1'b0, TWave} + {1'b0, StepSize} >= {1'b0, UpperLimit}) begin
        TWave  <= UpperLimit;
        waveUp <= 1'b0;
      end else begin
        TWave <= TWave + StepSize;
      end
    end else begin
      if ({1'b0, TWave} <= {1'b0, LowerLimit} + {1'b0, StepSize}) begin
        TWave  <= LowerLimit;
        waveUp <= 1'b1;
      end else begin
        TWave <= TWave - StepSize;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge MClk);
    #1;
  endtask

  task automatic sendCfg(input logic [15:0] u, input logic [15:0] l, input logic [15:0] s,
                         input logic withStop = 1'b0);
    CfgValid = 1'b1; CfgUpper = u; CfgLower = l; CfgStep = s; Stop = withStop;
    cyc();
    CfgValid = 1'b0; Stop = 1'b0;
  endtask

  task automatic chkLimits(input string tag, input logic [15:0] u, input logic [15:0] l,
                           input logic [15:0] s);
    chk({tag, "_upper"}, UpperLimit, u);
    chk({tag, "_lower"}, LowerLimit, l);
    chk({tag, "_step"},  StepSize,   s);
  endtask

  task automatic waitValley(input string tag);
    int n = 0;
    while (!ValleyPulse && n < 400) begin
      cyc();
      n++;
    end
    chk({tag, "_valley_seen"}, ValleyPulse, 1'b1);
  endtask

  initial begin
    RstN = 1'b0; Start = 1'b0; Stop = 1'b0; CfgValid = 1'b0;
    CfgUpper = '0; CfgLower = '0; CfgStep = '0;
    cyc(2);
    chk("rst_genen", GenEn, 0);
    chkLimits("rst", 16'hFFFF, 16'h0000, 16'h0001);
    chk("rst_ready", CfgReady, 1);
    chk("rst_err", CfgErr, 0);
    chk("rst_valley", ValleyPulse, 0);
    chk("rst_pcnt", PeriodCnt, 0);
    RstN = 1'b1;
    cyc();

    // IDLE config applies directly; Start enables the carrier.
    sendCfg(100, 10, 7);
    chkLimits("idle_cfg", 100, 10, 7);
    chk("idle_cfg_err", CfgErr, 0);
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("start_genen", GenEn, 1);
    chk("start_pcnt", PeriodCnt, 0);
    cyc(3);
    chk("no_early_valley", PeriodCnt, 0);
    waitValley("first");
    chk("first_pcnt", PeriodCnt, 1);

    // RUN update is deferred to the next valley.
    sendCfg(200, 0, 5);
    chk("pend_ready", CfgReady, 0);
    chkLimits("pend_hold", 100, 10, 7);
    waitValley("pend");
    chkLimits("pend_at_valley", 100, 10, 7);
    cyc();
    chkLimits("pend_applied", 200, 0, 5);
    chk("pend_ready_back", CfgReady, 1);
    chk("pend_pcnt", PeriodCnt, 2);

    // Invalid configs are consumed and flagged; a valid one clears the flag.
    sendCfg(50, 50, 1);
    chk("inv1_err", CfgErr, 1);
    chk("inv1_ready", CfgReady, 1);
    chkLimits("inv1", 200, 0, 5);
    sendCfg(50, 0, 60);
    chk("inv2_err", CfgErr, 1);
    chkLimits("inv2", 200, 0, 5);
    sendCfg(150, 20, 3);
    chk("valid_clr_err", CfgErr, 0);
    chk("valid_pend_ready", CfgReady, 0);

    // Stop in PEND applies the shadow at once and returns to IDLE.
    Stop = 1'b1; cyc(); Stop = 1'b0;
    chk("stop_genen", GenEn, 0);
    chkLimits("stop_apply", 150, 20, 3);
    chk("stop_ready", CfgReady, 1);
    chk("stop_pcnt", PeriodCnt, 2);
    cyc(5);
    chk("stop_pcnt_hold", PeriodCnt, 2);

    // Stop beats a same-cycle accept in RUN.
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("restart_pcnt", PeriodCnt, 0);
    sendCfg(80, 40, 100, 1'b1);
    chk("stopwin_genen", GenEn, 0);
    chk("stopwin_err", CfgErr, 0);
    chkLimits("stopwin", 150, 20, 3);

    // Reset while PEND discards the shadow.
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("run2_genen", GenEn, 1);
    sendCfg(300, 30, 9);
    chk("run2_pend_ready", CfgReady, 0);
    RstN = 1'b0; cyc(); RstN = 1'b1;
    chk("rst2_genen", GenEn, 0);
    chkLimits("rst2", 16'hFFFF, 16'h0000, 16'h0001);
    chk("rst2_ready", CfgReady, 1);
    cyc(3);
    chkLimits("rst2_no_shadow", 16'hFFFF, 16'h0000, 16'h0001);

    // Start and Stop together in IDLE stay in IDLE.
    Start = 1'b1; Stop = 1'b1; cyc(); Start = 1'b0; Stop = 1'b0;
    chk("startstop_genen", GenEn, 0);
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("idle_start_genen", GenEn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
